// File: rtl/fir_xifu_wb_pkg.sv
// -----------------------------------------------------------------------------
// Packages shared by the FIR XIFU writeback slice.
//
// cv32e40x_pkg : the subset of X-interface types used by the writeback stage
//                (result channel and memory-result channel payloads).
// fir_xifu_pkg : XIFU-local types: instruction encoding, EX/WB bundle,
//                regfile write port, writeback FSM states and the exception
//                codes reported on a memory fault.
// -----------------------------------------------------------------------------
package cv32e40x_pkg;

    localparam int X_ID_WIDTH = 4;

    // Payload of the coprocessor result channel.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    // Payload of the memory-result channel.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rdata;
        logic                  err;
    } x_mem_result_t;

endpackage

package fir_xifu_pkg;

    import cv32e40x_pkg::*;

    // XIFU register file address width (8 entries).
    localparam int XRF_AW = 3;

    // Exception codes returned with a faulting load/store.
    localparam logic [5:0] EXC_LOAD_FAULT  = 6'd5;
    localparam logic [5:0] EXC_STORE_FAULT = 6'd7;

    // All-zero encoding is a pipeline bubble.
    typedef enum logic [1:0] {
        INSTR_NONE     = 2'd0,
        INSTR_XFIRDOTP = 2'd1,
        INSTR_XFIRLW   = 2'd2,
        INSTR_XFIRSW   = 2'd3
    } fir_xifu_instr_t;

    // Registered EX/WB bundle.
    typedef struct packed {
        logic [31:0]           result;  // dot product, or post-incremented address
        logic [4:0]            rs1;     // core register receiving the new address
        logic [4:0]            rs2;
        logic [XRF_AW-1:0]     rd;      // XIFU register file destination
        fir_xifu_instr_t       instr;
        logic [X_ID_WIDTH-1:0] id;
    } fir_xifu_ex2wb_t;

    // XIFU register file write port.
    typedef struct packed {
        logic              we;
        logic [XRF_AW-1:0] waddr;
        logic [31:0]       wdata;
    } fir_xifu_wb2regfile_t;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_RESULT   = 2'd2
    } fir_xifu_wb_state_t;

endpackage

// File: rtl/fir_xifu_wb_if.sv
// -----------------------------------------------------------------------------
// cv32e40x_if_xif : slice of the X-interface carrying the result and the
// memory-result channels.
//
// Modports
//   coproc_result     (master) : drives result_valid/result, samples result_ready
//   core_result       (slave)  : samples result_valid/result, drives result_ready
//   coproc_mem_result (slave)  : samples mem_result_valid/mem_result
//   core_mem_result   (master) : drives mem_result_valid/mem_result
// -----------------------------------------------------------------------------
interface cv32e40x_if_xif;

    import cv32e40x_pkg::*;

    logic          result_valid;
    logic          result_ready;
    x_result_t     result;

    logic          mem_result_valid;
    x_mem_result_t mem_result;

    modport coproc_result (
        output result_valid,
        output result,
        input  result_ready
    );

    modport core_result (
        input  result_valid,
        input  result,
        output result_ready
    );

    modport coproc_mem_result (
        input  mem_result_valid,
        input  mem_result
    );

    modport core_mem_result (
        output mem_result_valid,
        output mem_result
    );

endinterface

// File: rtl/fir_xifu_wb.sv
// -----------------------------------------------------------------------------
// fir_xifu_wb : writeback stage of the FIR X-interface unit.
//
// Holds one instruction at a time. Dot products are written to the XIFU
// register file on entry; loads/stores wait for the matching memory result,
// loads write their data then. Every instruction finishes with one beat on
// the X-if result channel (post-incremented address for LW/SW, a plain
// completion for DOTP).
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous active-low reset
//   clear_i           synchronous flush back to IDLE
//   ex2wb_i           EX/WB register (instr==INSTR_NONE is a bubble)
//   ready_o           EX may replace ex2wb_i at the next edge
//   xif_mem_result_i  X-if memory-result channel (input)
//   xif_result_o      X-if result channel (output, result_ready is input)
//   wb2regfile_o      XIFU register file write port (one-cycle pulse)
// -----------------------------------------------------------------------------
module fir_xifu_wb
    import cv32e40x_pkg::*;
    import fir_xifu_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  fir_xifu_ex2wb_t                  ex2wb_i,
    output logic                             ready_o,
    cv32e40x_if_xif.coproc_mem_result        xif_mem_result_i,
    cv32e40x_if_xif.coproc_result            xif_result_o,
    output fir_xifu_wb2regfile_t             wb2regfile_o
);

    fir_xifu_wb_state_t    r_state_q;
    fir_xifu_wb_state_t    w_state_d;

    // Instruction context captured on entry
    logic [X_ID_WIDTH-1:0] r_id;
    logic [4:0]            r_rs1;
    logic [XRF_AW-1:0]     r_xrd;
    logic [31:0]           r_next_addr;
    logic                  r_is_lw;

    // Result channel registers
    logic [31:0]           r_data;
    logic [4:0]            r_rd;
    logic                  r_we;
    logic                  r_exc;
    logic [5:0]            r_exccode;

    logic                  w_bubble;
    logic                  w_mem_match;
    logic                  w_take;
    logic                  w_mem_done;
    logic                  w_ready;
    fir_xifu_wb2regfile_t  w_rf;
    logic                  w_unused_rs2;

    assign w_bubble    = (ex2wb_i.instr == INSTR_NONE);
    assign w_mem_match = xif_mem_result_i.mem_result_valid &&
                         (xif_mem_result_i.mem_result.id == r_id);

    // rs2 travels in the bundle for other stages only.
    assign w_unused_rs2 = ^ex2wb_i.rs2;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= WB_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM next state and combinational outputs
    always_comb begin
        w_state_d  = r_state_q;
        w_ready    = 1'b0;
        w_rf       = '0;
        w_take     = 1'b0;
        w_mem_done = 1'b0;

        case (r_state_q)
            WB_IDLE: begin
                if (w_bubble) begin
                    w_ready = 1'b1;
                end else begin
                    w_take = 1'b1;
                    if (ex2wb_i.instr == INSTR_XFIRDOTP) begin
                        w_rf.we    = 1'b1;
                        w_rf.waddr = ex2wb_i.rd;
                        w_rf.wdata = ex2wb_i.result;
                        w_state_d  = WB_RESULT;
                    end else begin
                        w_state_d  = WB_WAIT_MEM;
                    end
                end
            end

            WB_WAIT_MEM: begin
                // Results tagged for other instructions are not ours.
                if (w_mem_match) begin
                    w_mem_done = 1'b1;
                    if (r_is_lw && !xif_mem_result_i.mem_result.err) begin
                        w_rf.we    = 1'b1;
                        w_rf.waddr = r_xrd;
                        w_rf.wdata = xif_mem_result_i.mem_result.rdata;
                    end
                    w_state_d = WB_RESULT;
                end
            end

            WB_RESULT: begin
                if (xif_result_o.result_ready) begin
                    w_ready   = 1'b1;
                    w_state_d = WB_IDLE;
                end
            end

            default: begin
                w_state_d = WB_IDLE;
            end
        endcase

        // A flush overrides every transition and suppresses the write,
        // including a memory result landing in the same cycle.
        if (clear_i) begin
            w_state_d  = WB_IDLE;
            w_rf       = '0;
            w_take     = 1'b0;
            w_mem_done = 1'b0;
        end
    end

    // Instruction context and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id        <= '0;
            r_rs1       <= '0;
            r_xrd       <= '0;
            r_next_addr <= '0;
            r_is_lw     <= 1'b0;
            r_data      <= '0;
            r_rd        <= '0;
            r_we        <= 1'b0;
            r_exc       <= 1'b0;
            r_exccode   <= '0;
        end else if (clear_i) begin
            r_id        <= '0;
            r_rs1       <= '0;
            r_xrd       <= '0;
            r_next_addr <= '0;
            r_is_lw     <= 1'b0;
            r_data      <= '0;
            r_rd        <= '0;
            r_we        <= 1'b0;
            r_exc       <= 1'b0;
            r_exccode   <= '0;
        end else begin
            if (w_take) begin
                // DOTP completes with an all-zero result; LW/SW overwrite
                // these fields when their memory result arrives.
                r_id        <= ex2wb_i.id;
                r_rs1       <= ex2wb_i.rs1;
                r_xrd       <= ex2wb_i.rd;
                r_next_addr <= ex2wb_i.result;
                r_is_lw     <= (ex2wb_i.instr == INSTR_XFIRLW);
                r_data      <= '0;
                r_rd        <= '0;
                r_we        <= 1'b0;
                r_exc       <= 1'b0;
                r_exccode   <= '0;
            end
            if (w_mem_done) begin
                // The core writes the post-incremented address back to rs1
                // unless the access faulted.
                r_data <= r_next_addr;
                r_rd   <= r_rs1;
                r_we   <= ~xif_mem_result_i.mem_result.err;
                r_exc  <= xif_mem_result_i.mem_result.err;
                if (xif_mem_result_i.mem_result.err) begin
                    r_exccode <= r_is_lw ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
                end else begin
                    r_exccode <= '0;
                end
            end
        end
    end

    assign ready_o      = w_ready;
    assign wb2regfile_o = w_rf;

    assign xif_result_o.result_valid   = (r_state_q == WB_RESULT);
    assign xif_result_o.result.id      = r_id;
    assign xif_result_o.result.data    = r_data;
    assign xif_result_o.result.rd      = r_rd;
    assign xif_result_o.result.we      = r_we;
    assign xif_result_o.result.exc     = r_exc;
    assign xif_result_o.result.exccode = r_exccode;

endmodule

// File: tb/tb_fir_xifu_wb.sv
// -----------------------------------------------------------------------------
// Directed bench for fir_xifu_wb. Inputs change 1 time unit after a rising
// edge; outputs are checked 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_fir_xifu_wb;

    import cv32e40x_pkg::*;
    import fir_xifu_pkg::*;

    logic                 clk_i;
    logic                 rst_ni;
    logic                 clear_i;
    fir_xifu_ex2wb_t      ex2wb;
    logic                 ready;
    fir_xifu_wb2regfile_t rf;

    cv32e40x_if_xif xif ();

    int checks;
    int errors;

    fir_xifu_wb dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .ex2wb_i          (ex2wb),
        .ready_o          (ready),
        .xif_mem_result_i (xif),
        .xif_result_o     (xif),
        .wb2regfile_o     (rf)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input fir_xifu_instr_t instr, input logic [3:0] id,
                             input logic [31:0] result, input logic [4:0] rs1,
                             input logic [2:0] rd);
        ex2wb.instr  = instr;
        ex2wb.id     = id;
        ex2wb.result = result;
        ex2wb.rs1    = rs1;
        ex2wb.rs2    = 5'd0;
        ex2wb.rd     = rd;
    endtask

    task automatic set_mem(input logic valid, input logic [3:0] id,
                           input logic [31:0] rdata, input logic err);
        xif.mem_result_valid = valid;
        xif.mem_result.id    = id;
        xif.mem_result.rdata = rdata;
        xif.mem_result.err   = err;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        ex2wb   = '0;
        xif.result_ready = 1'b0;
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);

        // ---- reset state ----
        settle();
        chk("rst_valid", {31'd0, xif.result_valid}, 32'd0);
        chk("rst_rf_we", {31'd0, rf.we},            32'd0);
        chk("rst_ready", {31'd0, ready},            32'd1);
        chk("rst_data",  xif.result.data,           32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // ---- DOTP: write on entry, result next cycle ----
        xif.result_ready = 1'b1;
        set_instr(INSTR_XFIRDOTP, 4'd2, 32'h0000_1234, 5'd0, 3'd3);
        settle();
        chk("dotp_rf_we",    {31'd0, rf.we},            32'd1);
        chk("dotp_rf_waddr", {29'd0, rf.waddr},         32'd3);
        chk("dotp_rf_wdata", rf.wdata,                  32'h0000_1234);
        chk("dotp_ready0",   {31'd0, ready},            32'd0);
        chk("dotp_valid0",   {31'd0, xif.result_valid}, 32'd0);
        tick();
        ex2wb = '0;
        settle();
        chk("dotp_valid1",   {31'd0, xif.result_valid}, 32'd1);
        chk("dotp_id",       {28'd0, xif.result.id},    32'd2);
        chk("dotp_we",       {31'd0, xif.result.we},    32'd0);
        chk("dotp_ready1",   {31'd0, ready},            32'd1);
        chk("dotp_rf_pulse", {31'd0, rf.we},            32'd0);
        tick();
        settle();
        chk("dotp_done",     {31'd0, xif.result_valid}, 32'd0);

        // ---- LW: memory result at T+3 ----
        set_instr(INSTR_XFIRLW, 4'd1, 32'h1000_0004, 5'd10, 3'd5);
        settle();
        chk("lw_ready0", {31'd0, ready}, 32'd0);
        chk("lw_rf_we0", {31'd0, rf.we}, 32'd0);
        tick();
        ex2wb = '0;
        settle();
        chk("lw_wait_valid", {31'd0, xif.result_valid}, 32'd0);
        tick();
        tick();
        set_mem(1'b1, 4'd1, 32'hDEAD_BEEF, 1'b0);
        settle();
        chk("lw_rf_we",    {31'd0, rf.we},    32'd1);
        chk("lw_rf_waddr", {29'd0, rf.waddr}, 32'd5);
        chk("lw_rf_wdata", rf.wdata,          32'hDEAD_BEEF);
        chk("lw_valid_m",  {31'd0, xif.result_valid}, 32'd0);
        tick();
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);
        settle();
        chk("lw_valid",  {31'd0, xif.result_valid}, 32'd1);
        chk("lw_rd",     {27'd0, xif.result.rd},    32'd10);
        chk("lw_data",   xif.result.data,           32'h1000_0004);
        chk("lw_we",     {31'd0, xif.result.we},    32'd1);
        chk("lw_exc",    {31'd0, xif.result.exc},   32'd0);
        chk("lw_id",     {28'd0, xif.result.id},    32'd1);
        chk("lw_rf_one", {31'd0, rf.we},            32'd0);
        tick();

        // ---- SW: foreign id ignored, matching id completes once ----
        set_instr(INSTR_XFIRSW, 4'd4, 32'h2000_0008, 5'd7, 3'd0);
        settle();
        tick();
        ex2wb = '0;
        set_mem(1'b1, 4'd0, 32'h0BAD_0BAD, 1'b0);
        settle();
        chk("sw_foreign_rf", {31'd0, rf.we}, 32'd0);
        tick();
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);
        settle();
        chk("sw_foreign_valid", {31'd0, xif.result_valid}, 32'd0);
        set_mem(1'b1, 4'd4, 32'h1234_5678, 1'b0);
        settle();
        chk("sw_rf_we", {31'd0, rf.we}, 32'd0);
        tick();
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);
        settle();
        chk("sw_valid", {31'd0, xif.result_valid}, 32'd1);
        chk("sw_we",    {31'd0, xif.result.we},    32'd1);
        chk("sw_rd",    {27'd0, xif.result.rd},    32'd7);
        chk("sw_data",  xif.result.data,           32'h2000_0008);
        chk("sw_id",    {28'd0, xif.result.id},    32'd4);
        tick();
        settle();
        chk("sw_once",  {31'd0, xif.result_valid}, 32'd0);

        // ---- LW with bus error ----
        set_instr(INSTR_XFIRLW, 4'd3, 32'h3000_0000, 5'd2, 3'd6);
        settle();
        tick();
        ex2wb = '0;
        set_mem(1'b1, 4'd3, 32'h0000_0055, 1'b1);
        settle();
        chk("lwerr_rf_we", {31'd0, rf.we}, 32'd0);
        tick();
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);
        settle();
        chk("lwerr_valid",   {31'd0, xif.result_valid},  32'd1);
        chk("lwerr_exc",     {31'd0, xif.result.exc},    32'd1);
        chk("lwerr_exccode", {26'd0, xif.result.exccode}, 32'd5);
        chk("lwerr_we",      {31'd0, xif.result.we},     32'd0);
        tick();

        // ---- back-pressure on the result channel ----
        xif.result_ready = 1'b0;
        set_instr(INSTR_XFIRDOTP, 4'd5, 32'h0000_ABCD, 5'd0, 3'd1);
        settle();
        chk("bp_rf_we", {31'd0, rf.we}, 32'd1);
        tick();
        set_instr(INSTR_XFIRDOTP, 4'd6, 32'h0000_9999, 5'd0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_valid", {31'd0, xif.result_valid}, 32'd1);
            chk("bp_id",    {28'd0, xif.result.id},    32'd5);
            chk("bp_data",  xif.result.data,           32'd0);
            chk("bp_ready", {31'd0, ready},            32'd0);
            chk("bp_rf_we", {31'd0, rf.we},            32'd0);
            tick();
        end
        xif.result_ready = 1'b1;
        settle();
        chk("bp_release_ready", {31'd0, ready},         32'd1);
        chk("bp_release_id",    {28'd0, xif.result.id}, 32'd5);
        tick();
        settle();
        chk("bp_next_rf_we",    {31'd0, rf.we},    32'd1);
        chk("bp_next_rf_waddr", {29'd0, rf.waddr}, 32'd2);
        chk("bp_next_rf_wdata", rf.wdata,          32'h0000_9999);
        tick();
        ex2wb = '0;
        settle();
        chk("bp_next_id", {28'd0, xif.result.id}, 32'd6);
        tick();

        // ---- clear in WAIT_MEM drops a same-cycle and later memory result ----
        set_instr(INSTR_XFIRLW, 4'd7, 32'h0000_0044, 5'd3, 3'd4);
        settle();
        tick();
        ex2wb = '0;
        clear_i = 1'b1;
        set_mem(1'b1, 4'd7, 32'h1111_1111, 1'b0);
        settle();
        chk("clr_rf_we", {31'd0, rf.we}, 32'd0);
        tick();
        clear_i = 1'b0;
        settle();
        chk("clr_rf_we_after", {31'd0, rf.we},            32'd0);
        chk("clr_valid",       {31'd0, xif.result_valid}, 32'd0);
        chk("clr_idle_ready",  {31'd0, ready},            32'd1);
        chk("clr_rd",          {27'd0, xif.result.rd},    32'd0);
        tick();
        set_mem(1'b0, 4'd0, 32'd0, 1'b0);
        settle();
        chk("clr_no_result",   {31'd0, xif.result_valid}, 32'd0);

        // ---- async reset while in RESULT ----
        xif.result_ready = 1'b0;
        set_instr(INSTR_XFIRDOTP, 4'd9, 32'h0000_0001, 5'd0, 3'd7);
        settle();
        tick();
        ex2wb = '0;
        settle();
        chk("arst_pre_valid", {31'd0, xif.result_valid}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'd0, xif.result_valid}, 32'd0);
        chk("arst_id",    {28'd0, xif.result.id},    32'd0);
        chk("arst_ready", {31'd0, ready},            32'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        settle();
        chk("arst_stays_idle", {31'd0, xif.result_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
